// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer. Words are assembled MSB- or LSB-first
// and handed off through a single holding register with a valid/ready handshake.
module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       serial_in,
  input  logic                       serial_valid,
  input  logic                       clear,
  output logic [WIDTH-1:0]           parallel_out,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH)-1:0]   bit_count,
  output logic                       overrun
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;

  logic [WIDTH-1:0] sr_shifted;
  logic             bit_accept;
  logic             word_done;
  logic             consume;

  always_comb begin
    if (LSB_FIRST) begin
      sr_shifted = {serial_in, sr_q[WIDTH-1:1]};
    end else begin
      sr_shifted = {sr_q[WIDTH-2:0], serial_in};
    end
  end

  assign bit_accept = serial_valid && !clear;
  assign word_done  = bit_accept && (cnt_q == LAST_CNT);
  assign consume    = valid_q && out_ready;

  always_comb begin
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;

    if (clear) begin
      sr_d  = '0;
      cnt_d = '0;
    end else if (serial_valid) begin
      sr_d  = sr_shifted;
      cnt_d = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
    end

    // A completed word only replaces the holding register if the slot is free
    // or being consumed this same cycle; otherwise it is dropped.
    if (word_done) begin
      if (!valid_q || out_ready) begin
        hold_d  = sr_shifted;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q      <= '0;
      cnt_q     <= '0;
      hold_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign parallel_out = hold_q;
  assign out_valid    = valid_q;
  assign bit_count    = cnt_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench: an MSB-first and an LSB-first instance share stimulus
// and are compared against a queue-based word-assembly model.
module tb_sipo_deserializer;

  logic       clk = 1'b0;
  logic       reset, serial_in, serial_valid, clear, out_ready;
  logic [7:0] m_po, l_po;
  logic       m_v, l_v, m_o, l_o;
  logic [2:0] m_c, l_c;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic       q[$];
  logic [7:0] e_po_m, e_po_l;
  logic       e_valid, e_ovr;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
    .clear(clear), .parallel_out(m_po), .out_valid(m_v), .out_ready(out_ready),
    .bit_count(m_c), .overrun(m_o));

  sipo_deserializer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb (
    .clk(clk), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
    .clear(clear), .parallel_out(l_po), .out_valid(l_v), .out_ready(out_ready),
    .bit_count(l_c), .overrun(l_o));

  // One clock cycle: drive inputs, advance the model at the edge, settle 1 time unit.
  task automatic cyc(input logic sin, input logic sv, input logic clr,
                     input logic rdy, input logic rst);
    logic [7:0] wm, wl;
    logic       done, ovr_n;
    serial_in = sin; serial_valid = sv; clear = clr; out_ready = rdy; reset = rst;
    @(posedge clk);
    if (rst) begin
      q.delete();
      e_po_m = 8'h00; e_po_l = 8'h00; e_valid = 1'b0; e_ovr = 1'b0;
    end else begin
      done = 1'b0; ovr_n = 1'b0; wm = 8'h00; wl = 8'h00;
      if (clr) q.delete();
      else if (sv) begin
        q.push_back(sin);
        if (q.size() == 8) begin
          for (int i = 0; i < 8; i++) begin
            wm[7-i] = q[i];
            wl[i]   = q[i];
          end
          q.delete();
          done = 1'b1;
        end
      end
      if (done) begin
        if (!e_valid || rdy) begin
          e_po_m = wm; e_po_l = wl; e_valid = 1'b1;
        end else ovr_n = 1'b1;
      end else if (e_valid && rdy) e_valid = 1'b0;
      e_ovr = ovr_n;
    end
    #1;
  endtask

  // Sends d in arrival order d[7]..d[0]; rdy_last applies on the final bit.
  task automatic send(input logic [7:0] d, input logic rdy, input logic rdy_last);
    for (int i = 7; i >= 0; i--) cyc(d[i], 1'b1, 1'b0, (i == 0) ? rdy_last : rdy, 1'b0);
  endtask

  task automatic drain();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({m_po, l_po, m_v, l_v, m_c, l_c, m_o, l_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got po=%h/%h v=%b/%b cnt=%0d/%0d ovr=%b/%b, need all 0",
               m_po, l_po, m_v, l_v, m_c, l_c, m_o, l_o);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_msb_basic();
    send(8'hA5, 1'b1, 1'b1);
    n_checks++;
    if (m_po !== 8'hA5 || m_v !== 1'b1 || m_c !== 3'd0) begin
      n_fail++;
      $display("FAIL msb_a5: got po=%h v=%b cnt=%0d, need po=a5 v=1 cnt=0", m_po, m_v, m_c);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (m_v !== 1'b0 || m_po !== 8'hA5) begin
      n_fail++;
      $display("FAIL msb_consume: got po=%h v=%b, need po=a5 v=0", m_po, m_v);
    end
  endtask

  task automatic test_lsb();
    send(8'hA5, 1'b1, 1'b1);
    n_checks++;
    if (l_po !== 8'hA5 || l_v !== 1'b1) begin
      n_fail++;
      $display("FAIL lsb_a5: got po=%h v=%b, need po=a5 v=1", l_po, l_v);
    end
    send(8'hC0, 1'b1, 1'b1);
    n_checks++;
    if (l_po !== 8'h03 || m_po !== 8'hC0) begin
      n_fail++;
      $display("FAIL lsb_03: got lsb=%h msb=%h, need lsb=03 msb=c0", l_po, m_po);
    end
    drain();
  endtask

  task automatic test_gaps();
    logic [7:0] d;
    d = 8'h3C;
    drain();
    for (int c = 0; c < 16; c++) begin
      cyc(d[7 - c/2], (c % 2) == 0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (m_c !== 3'(q.size()) || l_c !== 3'(q.size()) || m_v !== e_valid) begin
        n_fail++;
        $display("FAIL gaps_count c=%0d: got cnt=%0d/%0d v=%b, need cnt=%0d v=%b",
                 c, m_c, l_c, m_v, q.size(), e_valid);
      end
    end
    n_checks++;
    if (m_po !== 8'h3C || l_po !== 8'h3C || m_v !== 1'b1) begin
      n_fail++;
      $display("FAIL gaps_word: got po=%h/%h v=%b, need 3c/3c v=1", m_po, l_po, m_v);
    end
    drain();
  endtask

  task automatic test_overrun();
    int pulses;
    drain();
    send(8'h11, 1'b0, 1'b0);
    pulses = 0;
    for (int i = 7; i >= 0; i--) begin
      cyc(i[0] ? 1'b0 : ((8'h22 >> i) & 1), 1'b1, 1'b0, 1'b0, 1'b0);
      if (m_o === 1'b1) pulses++;
    end
    n_checks++;
    if (m_o !== 1'b1 || m_po !== 8'h11 || m_v !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_drop: got ovr=%b po=%h v=%b, need ovr=1 po=11 v=1", m_o, m_po, m_v);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (m_o === 1'b1) pulses++;
    n_checks++;
    if (m_o !== 1'b0 || pulses != 1 || m_po !== 8'h11) begin
      n_fail++;
      $display("FAIL overrun_pulse: got ovr=%b pulses=%0d po=%h, need ovr=0 pulses=1 po=11",
               m_o, pulses, m_po);
    end
    send(8'h33, 1'b0, 1'b1);
    n_checks++;
    if (m_po !== 8'h33 || m_v !== 1'b1 || m_o !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_consume_load: got po=%h v=%b ovr=%b, need po=33 v=1 ovr=0",
               m_po, m_v, m_o);
    end
    drain();
  endtask

  task automatic test_clear();
    drain();
    send(8'h77, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (m_c !== 3'd5) begin
      n_fail++;
      $display("FAIL clear_precount: got cnt=%0d, need 5", m_c);
    end
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (m_c !== 3'd0 || m_v !== 1'b1 || m_po !== 8'h77) begin
      n_fail++;
      $display("FAIL clear_hold: got cnt=%0d v=%b po=%h, need cnt=0 v=1 po=77", m_c, m_v, m_po);
    end
    send(8'hF0, 1'b1, 1'b1);
    n_checks++;
    if (m_po !== 8'hF0 || l_po !== 8'h0F || m_v !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_word: got po=%h/%h v=%b, need f0/0f v=1", m_po, l_po, m_v);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    drain();
    send(8'h99, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    n_checks++;
    if ({m_po, l_po, m_v, l_v, m_c, l_c, m_o, l_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid: got po=%h/%h v=%b/%b cnt=%0d/%0d, need all 0",
               m_po, l_po, m_v, l_v, m_c, l_c);
    end
    send(8'h5A, 1'b0, 1'b0);
    n_checks++;
    if (m_po !== 8'h5A || l_po !== 8'h5A || m_v !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_fresh: got po=%h/%h v=%b, need 5a/5a v=1", m_po, l_po, m_v);
    end
    drain();
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      cyc(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
          1'($urandom), $urandom_range(0, 99) == 0);
      n_checks++;
      if (m_po !== e_po_m || l_po !== e_po_l || m_v !== e_valid || l_v !== e_valid ||
          m_c !== 3'(q.size()) || l_c !== 3'(q.size()) || m_o !== e_ovr || l_o !== e_ovr) begin
        n_fail++;
        $display("FAIL random c=%0d: got po=%h/%h v=%b/%b cnt=%0d/%0d ovr=%b/%b, need po=%h/%h v=%b cnt=%0d ovr=%b",
                 c, m_po, l_po, m_v, l_v, m_c, l_c, m_o, l_o,
                 e_po_m, e_po_l, e_valid, q.size(), e_ovr);
      end
    end
  endtask

  initial begin
    reset = 1'b1; serial_in = 1'b0; serial_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
    e_po_m = 8'h00; e_po_l = 8'h00; e_valid = 1'b0; e_ovr = 1'b0;
    test_reset();
    test_msb_basic();
    test_lsb();
    test_gaps();
    test_overrun();
    test_clear();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
